// File: rtl/exp_pulse_gen_pkg.sv
// Shared sizing for the synthetic pulse source; DATA_W tracks the shaping-filter input width.
package package_settings_gen;
  localparam int FILT_IN_W   = 14;
  localparam int DATA_W      = FILT_IN_W;
  localparam int AMP_W       = 14;
  localparam int PERIOD_W    = 16;
  localparam int DECAY_SHIFT = 6;
  localparam int FRAC_W      = 8;
  localparam int HOLDOFF     = 4;
  localparam int ACC_W       = DATA_W + FRAC_W;
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
  localparam int HOLD_W      = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
endpackage

// File: rtl/exp_pulse_gen_trig_ctrl.sv
// Injection control: period timer, trigger merge and holdoff. inject is combinational
// from this clock's request; trig_dropped is a registered one-clock strobe.
module gen_trig_ctrl
  import package_settings_gen::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                trig,
  input  logic                auto_en,
  input  logic [PERIOD_W-1:0] period,
  output logic                inject,
  output logic                trig_dropped
);

  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                drop_q, drop_d;
  logic                timer_run;
  logic                req;

  always_comb begin
    timer_run = auto_en && (period != '0);
    req       = trig || (timer_run && (timer_q == '0));
    inject    = enable && req && (hold_q == '0);
    timer_d   = timer_q;
    hold_d    = hold_q;
    drop_d    = 1'b0;
    if (enable) begin
      // A new period value is only picked up when the timer reloads.
      if (!timer_run)
        timer_d = '0;
      else if (timer_q == '0)
        timer_d = period - PERIOD_W'(1);
      else
        timer_d = timer_q - PERIOD_W'(1);

      if (inject)
        hold_d = HOLD_W'(HOLDOFF - 1);
      else if (hold_q != '0)
        hold_d = hold_q - HOLD_W'(1);

      drop_d = req && (hold_q != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      hold_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      hold_q  <= hold_d;
      drop_q  <= drop_d;
    end
  end

  assign trig_dropped = drop_q;

endmodule

// File: rtl/exp_pulse_gen.sv
// Preamp-like pulse source: step plus exponential decay on a baseline, one sample per clock.
// A request before edge n updates acc at edge n; sample_out shows the step after edge n+1.
module exp_pulse_gen
  import package_settings_gen::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                trig,
  input  logic                auto_en,
  input  logic [PERIOD_W-1:0] period,
  input  logic [AMP_W-1:0]    amplitude,
  input  logic [DATA_W-1:0]   baseline,
  output logic [DATA_W-1:0]   sample_out,
  output logic                sample_valid,
  output logic                pulse_start,
  output logic                trig_dropped,
  output logic                busy
);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  dec;
  logic [ACC_W-1:0]  inj_term;
  logic [ACC_W:0]    acc_sum;
  logic [DATA_W:0]   out_sum;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              valid_q, start_q, busy_q, inj_q;
  logic              inject;

  gen_trig_ctrl u_trig_ctrl (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .trig         (trig),
    .auto_en      (auto_en),
    .period       (period),
    .inject       (inject),
    .trig_dropped (trig_dropped)
  );

  always_comb begin
    // Below one decay step the tail is walked down by 1 so the pulse always ends at zero.
    if (acc_q >= ACC_W'(2 ** DECAY_SHIFT))
      dec = acc_q >> DECAY_SHIFT;
    else if (acc_q != '0)
      dec = ACC_W'(1);
    else
      dec = '0;

    inj_term = inject ? ACC_W'({amplitude, {FRAC_W{1'b0}}}) : '0;
    acc_sum  = {1'b0, acc_q} - {1'b0, dec} + {1'b0, inj_term};

    acc_d = acc_q;
    if (enable)
      acc_d = acc_sum[ACC_W] ? ACC_MAX : acc_sum[ACC_W-1:0];

    out_sum  = {1'b0, baseline} + {1'b0, acc_q[ACC_W-1:FRAC_W]};
    sample_d = out_sum[DATA_W] ? {DATA_W{1'b1}} : out_sum[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      inj_q    <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      valid_q <= enable;
      if (enable) begin
        inj_q    <= inject;
        sample_q <= sample_d;
        busy_q   <= (acc_q != '0);
        start_q  <= inj_q;
      end else begin
        start_q  <= 1'b0;
      end
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign pulse_start  = start_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_exp_pulse_gen.sv
// Directed and randomized checks of exp_pulse_gen against a cycle-level arithmetic model.
module tb_exp_pulse_gen;
  import package_settings_gen::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic                trig;
  logic                auto_en;
  logic [PERIOD_W-1:0] period;
  logic [AMP_W-1:0]    amplitude;
  logic [DATA_W-1:0]   baseline;
  logic [DATA_W-1:0]   sample_out;
  logic                sample_valid;
  logic                pulse_start;
  logic                trig_dropped;
  logic                busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: pulse height scaled by 2^FRAC_W, cycles until next timer fire, holdoff left.
  longint m_acc;
  int     m_tmr;
  int     m_hold;
  bit     m_pend;
  int     e_sample, e_valid, e_start, e_drop, e_busy;

  exp_pulse_gen dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .trig         (trig),
    .auto_en      (auto_en),
    .period       (period),
    .amplitude    (amplitude),
    .baseline     (baseline),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .pulse_start  (pulse_start),
    .trig_dropped (trig_dropped),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_tmr = 0; m_hold = 0; m_pend = 0;
    e_sample = 0; e_valid = 0; e_start = 0; e_drop = 0; e_busy = 0;
  endtask

  task automatic model_edge();
    bit     req, inj, timer_on;
    longint s, dec;
    if (reset) begin
      model_reset();
      return;
    end
    if (!enable) begin
      e_valid = 0; e_start = 0; e_drop = 0;
      return;
    end
    timer_on = auto_en && (period != 0);
    req      = trig || (timer_on && m_tmr == 0);
    inj      = req && (m_hold == 0);
    e_drop   = (req && m_hold != 0) ? 1 : 0;
    s        = longint'(baseline) + (m_acc / 256);
    e_sample = (s > 16383) ? 16383 : int'(s);
    e_valid  = 1;
    e_busy   = (m_acc != 0) ? 1 : 0;
    e_start  = m_pend ? 1 : 0;
    if (m_acc == 0)      dec = 0;
    else if (m_acc < 64) dec = 1;
    else                 dec = m_acc / 64;
    m_acc = m_acc - dec + (inj ? longint'(amplitude) * 256 : 0);
    if (m_acc > 64'd4194303) m_acc = 64'd4194303;
    m_pend = inj;
    if (!timer_on)       m_tmr = 0;
    else if (m_tmr == 0) m_tmr = int'(period) - 1;
    else                 m_tmr = m_tmr - 1;
    if (inj)             m_hold = HOLDOFF - 1;
    else if (m_hold > 0) m_hold = m_hold - 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("sample_out",   32'(sample_out),   e_sample);
    chk("sample_valid", 32'(sample_valid), e_valid);
    chk("pulse_start",  32'(pulse_start),  e_start);
    chk("trig_dropped", 32'(trig_dropped), e_drop);
    chk("busy",         32'(busy),         e_busy);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((busy || m_acc != 0) && k < 4000) begin cyc(); k++; end
    chk(tag, 32'(busy), 0);
  endtask

  initial begin
    int n, starts, drops;
    reset = 1'b1; enable = 1'b0; trig = 1'b0; auto_en = 1'b0;
    period = '0; amplitude = '0; baseline = '0;
    model_reset();
    cyc(); cyc();
    #2 reset = 1'b0;

    // Single pulse: step, then exponential decay back to baseline.
    enable = 1'b1; baseline = 14'd100; amplitude = 14'd1000;
    cyc();
    chk("first baseline", 32'(sample_out), 100);
    trig = 1'b1; cyc(); trig = 1'b0;
    cyc();
    chk("step height", 32'(sample_out), 1100);
    chk("step start",  32'(pulse_start), 1);
    cyc();
    chk("first decay", 32'(sample_out), 1084);
    drain("single drain");
    chk("tail baseline", 32'(sample_out), 100);

    // Periodic mode.
    period = 16'd50; amplitude = 14'd500; auto_en = 1'b1;
    cyc(); cyc();
    chk("auto first pulse", 32'(pulse_start), 1);
    for (int p = 0; p < 3; p++) begin
      n = 0;
      do begin cyc(); n++; end while (!pulse_start && n < 200);
      chk("auto interval", n, 50);
    end

    // Trigger coincident with timer expiry.
    n = 0;
    while (!(m_tmr == 0 && m_hold == 0) && n < 100) begin cyc(); n++; end
    chk("coincide wait", m_tmr, 0);
    trig = 1'b1; cyc(); trig = 1'b0;
    chk("coincide drop", 32'(trig_dropped), 0);
    cyc();
    chk("coincide start", 32'(pulse_start), 1);
    cyc();
    chk("coincide single", 32'(pulse_start), 0);

    // Back-to-back triggers: second one falls in holdoff.
    auto_en = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    starts = 0; drops = 0;
    trig = 1'b1; cyc(); starts += 32'(pulse_start); drops += 32'(trig_dropped);
    cyc(); starts += 32'(pulse_start); drops += 32'(trig_dropped);
    trig = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); starts += 32'(pulse_start); drops += 32'(trig_dropped);
    end
    chk("b2b starts", starts, 1);
    chk("b2b drops",  drops,  1);

    // Pile-up into saturation.
    drain("pre-pileup drain");
    baseline = '0; amplitude = 14'd16383;
    trig = 1'b1; cyc(); trig = 1'b0;
    cyc(); cyc(); cyc();
    trig = 1'b1; cyc(); trig = 1'b0;
    chk("acc clamp", 32'(dut.acc_q), 32'(ACC_MAX));
    cyc();
    chk("sample clamp", 32'(sample_out), 16383);
    cyc();
    chk("decay after clamp", 32'(sample_out), 16128);
    for (int i = 0; i < 10; i++) cyc();

    // Enable freeze mid-decay with a trigger inside the freeze.
    enable = 1'b0;
    cyc();
    n = int'(sample_out);
    for (int i = 0; i < 20; i++) begin
      trig = (i == 7);
      cyc();
      chk("freeze valid", 32'(sample_valid), 0);
      chk("freeze hold",  32'(sample_out), n);
    end
    trig = 1'b0;
    chk("freeze acc", 32'(dut.acc_q), 32'(m_acc));
    enable = 1'b1;
    for (int i = 0; i < 6; i++) cyc();

    // Async reset between edges, mid-pulse.
    baseline = 14'd321;
    #2 reset = 1'b1;
    #1;
    chk("arst sample", 32'(sample_out), 0);
    chk("arst valid",  32'(sample_valid), 0);
    chk("arst start",  32'(pulse_start), 0);
    chk("arst drop",   32'(trig_dropped), 0);
    chk("arst busy",   32'(busy), 0);
    model_reset();
    cyc();
    #2 reset = 1'b0;
    cyc();
    chk("post-reset baseline", 32'(sample_out), 321);
    chk("post-reset busy",     32'(busy), 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) begin
        auto_en  = ($urandom_range(0, 2) != 0);
        period   = 16'($urandom_range(0, 40));
        baseline = 14'($urandom_range(0, 16383));
      end
      enable    = ($urandom_range(0, 7) != 0);
      trig      = ($urandom_range(0, 5) == 0);
      amplitude = 14'($urandom_range(0, 16383));
      if (i == 900) begin
        #2 reset = 1'b1;
        #1 model_reset();
        cyc();
        #2 reset = 1'b0;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exp_pulse_gen.md
Name: exp_pulse_gen

Overview:
- Synthetic detector-signal source for exercising the trapezoidal shaping filter: produces preamp-like pulses (instantaneous step, exponential decay) on a programmable baseline, one sample per clock.
- Pulses are injected by an external trigger or an internal period timer; overlapping pulses pile up additively with saturation.
- Sits directly in front of the filter input, in simulation benches and on the board as a built-in test source.

Parameters:
- DATA_W, 14, width of sample_out; matches the filter input data width.
- AMP_W, 14, width of amplitude.
- PERIOD_W, 16, width of period.
- DECAY_SHIFT, 6, decay per clock is acc>>DECAY_SHIFT; tau is about 2^DECAY_SHIFT clocks.
- FRAC_W, 8, fractional bits carried in the decay accumulator.
- HOLDOFF, 4, minimum clocks between two accepted injections.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-high.
- enable, in, 1, run/freeze for the whole block.
- trig, in, 1, external injection request; sampled every enabled clock.
- auto_en, in, 1, enables periodic injection.
- period, in, PERIOD_W, clocks between automatic injections; 0 disables the timer.
- amplitude, in, AMP_W, pulse height in output LSBs; sampled at injection.
- baseline, in, DATA_W, constant offset added to the pulse height.
- sample_out, out, DATA_W, generated sample.
- sample_valid, out, 1, high on clocks where sample_out carries a new sample.
- pulse_start, out, 1, one-clock strobe aligned with the first output sample of each injected pulse.
- trig_dropped, out, 1, one-clock strobe when a request is rejected by holdoff.
- busy, out, 1, pulse height (acc) is nonzero.

Behaviour:
- Reset (async, active-high): acc=0, timer=0, holdoff counter=0.
  - All outputs are 0: sample_out, sample_valid, pulse_start, trig_dropped, busy.
  - Baseline is not output until the first enabled clock.
- Accumulator acc: unsigned, DATA_W+FRAC_W bits, holds the pulse height scaled by 2^FRAC_W.
- Per enabled clock, the decay term is:
  - dec = acc>>DECAY_SHIFT if acc >= 2^DECAY_SHIFT;
  - 1 if 0 < acc < 2^DECAY_SHIFT, so the pulse always reaches 0;
  - 0 if acc = 0.
- acc_next = acc - dec + (inject ? amplitude<<FRAC_W : 0), saturated to 2^(DATA_W+FRAC_W)-1.
- Request: req = trig | (auto_en & period!=0 & timer==0).
  - trig and timer expiry in the same clock produce one injection only.
- Holdoff:
  - inject = req & (holdoff_cnt==0).
  - On inject, holdoff_cnt loads HOLDOFF-1 and then counts down to 0.
  - req while holdoff_cnt!=0 sets trig_dropped (registered) and does not inject.
- Period timer:
  - Counts down each enabled clock while auto_en & period!=0.
  - At 0 it raises req and reloads period-1.
  - When auto_en=0 or period=0 the timer is held at 0.
  - A period change takes effect at the next reload.
- Output stage (registered): sample_out = min(baseline + acc[DATA_W+FRAC_W-1:FRAC_W], 2^DATA_W-1).
  - The output is computed from the updated acc.
- Latency: trig high before clock edge n → acc updated at edge n → sample_out at edge n+1 shows the step.
  - pulse_start and sample_valid are high in that same cycle.
- busy is registered from acc!=0, aligned with sample_out.
- enable=0:
  - acc, timer and holdoff counters hold.
  - trig and timer requests are ignored, with no drop strobe.
  - sample_valid=0; sample_out holds its last value.
- Reset asserted mid-pulse clears everything immediately; no partial pulse resumes after reset.

Decomposition:
- Package package_settings_gen holds:
  - DATA_W, AMP_W, PERIOD_W, DECAY_SHIFT, FRAC_W, HOLDOFF;
  - the derived ACC_W = DATA_W+FRAC_W;
  - ACC_MAX.
- DATA_W is kept equal to the filter's input data width constant.
- One sub-module: gen_trig_ctrl. It contains the period timer, request merge and holdoff counter, with outputs inject and trig_dropped.
- Decay and saturation arithmetic stays in exp_pulse_gen.

Test Plan:
- Single pulse, step and decay: reset, enable=1, baseline=100, amplitude=1000, one trig.
  - Expected: sample_out goes 100 → 1100 (pulse_start=1) → 1084 on the next clock (acc 256000→252000).
  - Decay continues monotonically to exactly 100; busy falls when acc=0.
- Periodic mode: auto_en=1, period=50, amplitude=500, no trig.
  - Expected: pulse_start every 50 clocks exactly.
  - The first pulse appears 2 clocks after auto_en is raised.
- Holdoff and coincidence:
  - trig on two consecutive clocks: one pulse_start, one trig_dropped.
  - trig coincident with timer expiry: a single injection and no drop.
- Pile-up and saturation: amplitude=16383, baseline=0, trig twice spaced HOLDOFF apart.
  - Expected: sample_out clamps at 16383 and acc holds ACC_MAX on the injection clock.
  - Decay then resumes normally from the clamped value.
- Enable freeze: deassert enable mid-decay for 20 clocks.
  - Expected: sample_valid=0 and sample_out frozen.
  - Decay resumes from the same acc value after enable returns.
  - A trig during the freeze produces nothing.
- Async reset mid-pulse: assert reset between clock edges.
  - Expected: all outputs 0 immediately, before the next edge.
  - After release, the first enabled sample equals baseline.
